// File: rtl/exec_core_if.sv
// Execute-stage bus for exec_core: fetched instruction and register-file
// operands in, register addresses, write-back, branch/halt and debug status out.
interface exec_core_if;
  logic [7:0] instruction;
  logic [7:0] reg_data0;
  logic [7:0] reg_data1;
  logic [1:0] reg_addr_0;
  logic [1:0] reg_addr_1;
  logic [1:0] reg_addr_w;
  logic       reg_w_en;
  logic [7:0] reg_wdata;
  logic       branch;
  logic [7:0] branch_offset;
  logic       halt;
  logic       zero;
  logic       mem_w_en;
  logic       stack_w_en;
  logic       stack_r_en;
  logic       stack_full;
  logic       stack_empty;

  // Fetch/register-file side drives the instruction and operands
  modport master (
    output instruction, reg_data0, reg_data1,
    input  reg_addr_0, reg_addr_1, reg_addr_w, reg_w_en, reg_wdata, branch, branch_offset,
           halt, zero, mem_w_en, stack_w_en, stack_r_en, stack_full, stack_empty
  );

  // Execute core side
  modport slave (
    input  instruction, reg_data0, reg_data1,
    output reg_addr_0, reg_addr_1, reg_addr_w, reg_w_en, reg_wdata, branch, branch_offset,
           halt, zero, mem_w_en, stack_w_en, stack_r_en, stack_full, stack_empty
  );
endinterface

// File: rtl/exec_core.sv
// exec_core: single-cycle decode + 8-bit ALU + data memory for the ExceptioNull CPU.
// Optional descending hardware stack sharing data memory, enabled by `EXEC_STACK_EN.
module exec_core #(
  parameter int unsigned MEM_DEPTH = 16
) (
  input logic        clk,
  input logic        rst_n,
  exec_core_if.slave bus
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluXor = 3'b100,
    AluSlt = 3'b101,
    AluShl = 3'b110,
    AluShr = 3'b111
  } alu_op_e;

  logic [3:0] opcode;
  logic [7:0] imm_sext;
  alu_op_e    alu_op;
  logic       use_imm, dec_w, dec_sw, dec_lw, dec_push, dec_pop, dec_beqz, dec_halt;
  logic [7:0] alu_b, alu_result, rd_data;
  logic [7:0] mem_q [MEM_DEPTH];
  logic       mem_we;
  logic [AW-1:0] wr_addr;

  assign opcode   = bus.instruction[7:4];
  assign imm_sext = {{6{bus.instruction[1]}}, bus.instruction[1:0]};

  // Opcode decode into ALU control and raw (ungated) enables
  always_comb begin
    alu_op   = AluAdd;
    use_imm  = 1'b0;
    dec_w    = 1'b0;
    dec_sw   = 1'b0;
    dec_lw   = 1'b0;
    dec_push = 1'b0;
    dec_pop  = 1'b0;
    dec_beqz = 1'b0;
    dec_halt = 1'b0;
    case (opcode)
      4'h1: begin alu_op = AluAdd; dec_w = 1'b1; end
      4'h2: begin alu_op = AluSub; dec_w = 1'b1; end
      4'h3: begin alu_op = AluAnd; dec_w = 1'b1; end
      4'h4: begin alu_op = AluOr;  dec_w = 1'b1; end
      4'h5: begin alu_op = AluXor; dec_w = 1'b1; end
      4'h6: begin alu_op = AluAdd; dec_w = 1'b1; use_imm = 1'b1; end
      4'h7: begin alu_op = AluSlt; dec_w = 1'b1; end
      4'h8: begin alu_op = AluShl; dec_w = 1'b1; end
      4'h9: begin alu_op = AluShr; dec_w = 1'b1; end
      4'hA: begin dec_w = 1'b1; dec_lw = 1'b1; end
      4'hB: dec_sw = 1'b1;
`ifdef EXEC_STACK_EN
      4'hC: dec_push = 1'b1;
      4'hD: begin dec_w = 1'b1; dec_pop = 1'b1; end
`endif
      4'hE: dec_beqz = 1'b1;
      4'hF: dec_halt = 1'b1;
      default: ;
    endcase
  end

  // Operand B select; BEQZ adds zero so the zero flag reflects R
  always_comb begin
    alu_b = bus.reg_data1;
    if (use_imm)       alu_b = imm_sext;
    else if (dec_beqz) alu_b = 8'h00;
  end

  // 8-bit ALU, modulo-256 arithmetic
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      AluAdd: alu_result = bus.reg_data0 + alu_b;
      AluSub: alu_result = bus.reg_data0 - alu_b;
      AluAnd: alu_result = bus.reg_data0 & alu_b;
      AluOr:  alu_result = bus.reg_data0 | alu_b;
      AluXor: alu_result = bus.reg_data0 ^ alu_b;
      AluSlt: alu_result = {7'd0, $signed(bus.reg_data0) < $signed(alu_b)};
      AluShl: alu_result = {bus.reg_data0[6:0], 1'b0};
      AluShr: alu_result = {1'b0, bus.reg_data0[7:1]};
      default: alu_result = 8'h00;
    endcase
  end

  assign bus.reg_addr_0    = bus.instruction[3:2];
  assign bus.reg_addr_1    = bus.instruction[1:0];
  assign bus.reg_addr_w    = bus.instruction[3:2];
  assign bus.branch_offset = imm_sext;
  assign bus.zero          = (alu_result == 8'h00);
  // Enables and branch/halt are held low while reset is asserted
  assign bus.reg_w_en      = dec_w & rst_n;
  assign bus.mem_w_en      = dec_sw & rst_n;
  assign bus.stack_w_en    = dec_push & rst_n;
  assign bus.stack_r_en    = dec_pop & rst_n;
  assign bus.branch        = dec_beqz & (bus.reg_data0 == 8'h00) & rst_n;
  assign bus.halt          = dec_halt & rst_n;
  assign bus.reg_wdata     = (dec_lw | dec_pop) ? rd_data : alu_result;

`ifdef EXEC_STACK_EN
  localparam logic [AW:0] SpEmpty = MEM_DEPTH[AW:0];
  localparam logic [AW:0] SpOne   = (AW + 1)'(1);

  logic [AW:0] sp_q, sp_m1;
  logic        push_ok;

  assign sp_m1           = sp_q - SpOne;
  assign bus.stack_full  = (sp_q == '0);
  assign bus.stack_empty = (sp_q == SpEmpty);
  assign push_ok         = bus.stack_w_en & ~bus.stack_full;
  assign mem_we          = bus.mem_w_en | push_ok;
  assign wr_addr         = push_ok ? sp_m1[AW-1:0] : bus.reg_data1[AW-1:0];

  // Asynchronous read: LW by address, POP from top of stack (0x00 when empty)
  always_comb begin
    rd_data = mem_q[bus.reg_data1[AW-1:0]];
    if (dec_pop) rd_data = bus.stack_empty ? 8'h00 : mem_q[sp_q[AW-1:0]];
  end

  // Stack pointer: full pushes and empty pops leave it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= SpEmpty;
    end else if (push_ok) begin
      sp_q <= sp_m1;
    end else if (bus.stack_r_en && !bus.stack_empty) begin
      sp_q <= sp_q + SpOne;
    end
  end
`else
  assign bus.stack_full  = 1'b0;
  assign bus.stack_empty = 1'b1;
  assign mem_we          = bus.mem_w_en;
  assign wr_addr         = bus.reg_data1[AW-1:0];

  // Asynchronous LW read
  always_comb begin
    rd_data = mem_q[bus.reg_data1[AW-1:0]];
  end
`endif

  // Data memory: cleared by reset, single write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[wr_addr] <= bus.reg_data0;
    end
  end
endmodule

// File: tb/tb_exec_core.sv
// Directed self-checking bench for exec_core (MEM_DEPTH = 16).
module tb_exec_core;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  exec_core_if bus ();

  exec_core #(.MEM_DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ins;
    logic [7:0] r;
    logic [7:0] t;
    logic [7:0] wd;
    logic       wen;
    logic       z;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] ins, input logic [7:0] r, input logic [7:0] t);
    bus.instruction = ins;
    bus.reg_data0   = r;
    bus.reg_data1   = t;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(8'h11, 8'h01, 8'h02);
    checks++;
    if (bus.reg_w_en !== 1'b0) begin
      failures++; $display("FAIL reset_wen got=%b exp=0", bus.reg_w_en);
    end
    checks++;
    if (bus.reg_wdata !== 8'h03) begin
      failures++; $display("FAIL reset_wdata_follows got=%h exp=03", bus.reg_wdata);
    end
    checks++;
    if (bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_stack_flags got=%b%b exp=10", bus.stack_empty, bus.stack_full);
    end
    drive(8'hF0, 8'h00, 8'h00);
    checks++;
    if (bus.halt !== 1'b0) begin
      failures++; $display("FAIL reset_halt got=%b exp=0", bus.halt);
    end
    drive(8'hE2, 8'h00, 8'h00);
    checks++;
    if (bus.branch !== 1'b0) begin
      failures++; $display("FAIL reset_branch got=%b exp=0", bus.branch);
    end
    drive(8'hB1, 8'h77, 8'h03);
    checks++;
    if (bus.mem_w_en !== 1'b0) begin
      failures++; $display("FAIL reset_mem_w_en got=%b exp=0", bus.mem_w_en);
    end
    drive(8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu();
    vec_t v [10];
    v[0] = '{8'h11, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0};  // ADD
    v[1] = '{8'h21, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1};  // SUB
    v[2] = '{8'h63, 8'h03, 8'h00, 8'h02, 1'b1, 1'b0};  // ADDI imm=-1
    v[3] = '{8'h71, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0};  // SLT signed
    v[4] = '{8'h90, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0};  // SHR
    v[5] = '{8'h80, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0};  // SHL
    v[6] = '{8'h31, 8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0};  // AND
    v[7] = '{8'h41, 8'hF0, 8'h0C, 8'hFC, 1'b1, 1'b0};  // OR
    v[8] = '{8'h51, 8'hFF, 8'h0F, 8'hF0, 1'b1, 1'b0};  // XOR
    v[9] = '{8'h71, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1};  // SLT false
    for (int i = 0; i < 10; i++) begin
      drive(v[i].ins, v[i].r, v[i].t);
      checks++;
      if (bus.reg_wdata !== v[i].wd || bus.reg_w_en !== v[i].wen || bus.zero !== v[i].z) begin
        failures++;
        $display("FAIL alu[%0d] got wd=%h wen=%b z=%b exp wd=%h wen=%b z=%b", i,
                 bus.reg_wdata, bus.reg_w_en, bus.zero, v[i].wd, v[i].wen, v[i].z);
      end
    end
    drive(8'h5B, 8'h00, 8'h00);
    checks++;
    if (bus.reg_addr_0 !== 2'd2 || bus.reg_addr_1 !== 2'd3 || bus.reg_addr_w !== 2'd2) begin
      failures++;
      $display("FAIL reg_addrs got=%0d,%0d,%0d exp=2,3,2", bus.reg_addr_0, bus.reg_addr_1,
               bus.reg_addr_w);
    end
  endtask

  task automatic test_mem();
    drive(8'hB1, 8'hA5, 8'h03);
    checks++;
    if (bus.mem_w_en !== 1'b1 || bus.reg_w_en !== 1'b0) begin
      failures++;
      $display("FAIL sw_enables got mw=%b rw=%b exp mw=1 rw=0", bus.mem_w_en, bus.reg_w_en);
    end
    step();
    drive(8'hA1, 8'h00, 8'h03);
    checks++;
    if (bus.reg_wdata !== 8'hA5 || bus.reg_w_en !== 1'b1) begin
      failures++;
      $display("FAIL lw_same got wd=%h wen=%b exp wd=a5 wen=1", bus.reg_wdata, bus.reg_w_en);
    end
    drive(8'hA1, 8'h00, 8'h13);
    checks++;
    if (bus.reg_wdata !== 8'hA5) begin
      failures++; $display("FAIL lw_alias got=%h exp=a5", bus.reg_wdata);
    end
    drive(8'hA1, 8'h00, 8'h04);
    checks++;
    if (bus.reg_wdata !== 8'h00) begin
      failures++; $display("FAIL lw_other got=%h exp=00", bus.reg_wdata);
    end
    step();
  endtask

  task automatic test_branch();
    drive(8'hE2, 8'h00, 8'h00);
    checks++;
    if (bus.branch !== 1'b1 || bus.branch_offset !== 8'hFE || bus.zero !== 1'b1) begin
      failures++;
      $display("FAIL beqz_taken got br=%b off=%h z=%b exp br=1 off=fe z=1", bus.branch,
               bus.branch_offset, bus.zero);
    end
    checks++;
    if (bus.reg_w_en !== 1'b0) begin
      failures++; $display("FAIL beqz_wen got=%b exp=0", bus.reg_w_en);
    end
    drive(8'hE1, 8'h01, 8'h00);
    checks++;
    if (bus.branch !== 1'b0 || bus.branch_offset !== 8'h01) begin
      failures++;
      $display("FAIL beqz_not got br=%b off=%h exp br=0 off=01", bus.branch, bus.branch_offset);
    end
    drive(8'hF0, 8'h00, 8'h00);
    checks++;
    if (bus.halt !== 1'b1 || bus.reg_w_en !== 1'b0) begin
      failures++; $display("FAIL halt got h=%b wen=%b exp h=1 wen=0", bus.halt, bus.reg_w_en);
    end
    drive(8'h00, 8'h12, 8'h34);
    checks++;
    if (bus.reg_w_en !== 1'b0 || bus.mem_w_en !== 1'b0 || bus.halt !== 1'b0) begin
      failures++;
      $display("FAIL nop got wen=%b mw=%b h=%b exp 0,0,0", bus.reg_w_en, bus.mem_w_en, bus.halt);
    end
  endtask

`ifdef EXEC_STACK_EN
  task automatic test_stack();
    logic [7:0] exp_pop [3];
    exp_pop[0] = 8'h22; exp_pop[1] = 8'h11; exp_pop[2] = 8'h00;
    drive(8'hC0, 8'h11, 8'h00);
    checks++;
    if (bus.stack_w_en !== 1'b1 || bus.reg_w_en !== 1'b0) begin
      failures++;
      $display("FAIL push_en got sw=%b rw=%b exp sw=1 rw=0", bus.stack_w_en, bus.reg_w_en);
    end
    step();
    drive(8'hC0, 8'h22, 8'h00);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(8'hD0, 8'h00, 8'h00);
      checks++;
      if (bus.reg_wdata !== exp_pop[i] || bus.reg_w_en !== 1'b1 || bus.stack_r_en !== 1'b1) begin
        failures++;
        $display("FAIL pop[%0d] got wd=%h wen=%b exp wd=%h wen=1", i, bus.reg_wdata,
                 bus.reg_w_en, exp_pop[i]);
      end
      step();
    end
    checks++;
    if (bus.stack_empty !== 1'b1) begin
      failures++; $display("FAIL stack_empty got=%b exp=1", bus.stack_empty);
    end
    for (int i = 1; i <= 16; i++) begin
      drive(8'hC0, 8'(i), 8'h00);
      step();
    end
    checks++;
    if (bus.stack_full !== 1'b1 || bus.stack_empty !== 1'b0) begin
      failures++;
      $display("FAIL stack_full got f=%b e=%b exp f=1 e=0", bus.stack_full, bus.stack_empty);
    end
    drive(8'hC0, 8'hEE, 8'h00);
    step();
    drive(8'hD0, 8'h00, 8'h00);
    checks++;
    if (bus.reg_wdata !== 8'h10) begin
      failures++; $display("FAIL push_dropped got=%h exp=10", bus.reg_wdata);
    end
    step();
    checks++;
    if (bus.stack_full !== 1'b0) begin
      failures++; $display("FAIL full_cleared got=%b exp=0", bus.stack_full);
    end
  endtask
`else
  task automatic test_stack();
    drive(8'hC0, 8'h11, 8'h00);
    checks++;
    if (bus.stack_w_en !== 1'b0 || bus.reg_w_en !== 1'b0 || bus.mem_w_en !== 1'b0) begin
      failures++;
      $display("FAIL push_nop got sw=%b rw=%b mw=%b exp 0,0,0", bus.stack_w_en, bus.reg_w_en,
               bus.mem_w_en);
    end
    step();
    drive(8'hD0, 8'h00, 8'h00);
    checks++;
    if (bus.stack_r_en !== 1'b0 || bus.reg_w_en !== 1'b0) begin
      failures++;
      $display("FAIL pop_nop got sr=%b rw=%b exp 0,0", bus.stack_r_en, bus.reg_w_en);
    end
    step();
    checks++;
    if (bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0) begin
      failures++;
      $display("FAIL stack_tied got e=%b f=%b exp e=1 f=0", bus.stack_empty, bus.stack_full);
    end
    drive(8'hA1, 8'h00, 8'h03);
    checks++;
    if (bus.reg_wdata !== 8'hA5) begin
      failures++; $display("FAIL push_no_write got=%h exp=a5", bus.reg_wdata);
    end
  endtask
`endif

  task automatic test_reset_mid();
    drive(8'hB1, 8'h5A, 8'h07);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_w_en !== 1'b0) begin
      failures++; $display("FAIL midrst_mem_w_en got=%b exp=0", bus.mem_w_en);
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'hA1, 8'h00, 8'h07);
    checks++;
    if (bus.reg_wdata !== 8'h00) begin
      failures++; $display("FAIL midrst_no_write got=%h exp=00", bus.reg_wdata);
    end
    drive(8'hA1, 8'h00, 8'h03);
    checks++;
    if (bus.reg_wdata !== 8'h00) begin
      failures++; $display("FAIL midrst_cleared got=%h exp=00", bus.reg_wdata);
    end
    checks++;
    if (bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0) begin
      failures++;
      $display("FAIL midrst_sp got e=%b f=%b exp e=1 f=0", bus.stack_empty, bus.stack_full);
    end
    step();
  endtask

  task automatic test_back_to_back();
    drive(8'hB1, 8'h3C, 8'h09);
    step();
    drive(8'hB1, 8'hC3, 8'h0A);
    checks++;
    if (bus.mem_w_en !== 1'b1) begin
      failures++; $display("FAIL b2b_sw2_en got=%b exp=1", bus.mem_w_en);
    end
    step();
    drive(8'hA1, 8'h00, 8'h09);
    checks++;
    if (bus.reg_wdata !== 8'h3C) begin
      failures++; $display("FAIL b2b_lw9 got=%h exp=3c", bus.reg_wdata);
    end
    drive(8'hA1, 8'h00, 8'h0A);
    checks++;
    if (bus.reg_wdata !== 8'hC3) begin
      failures++; $display("FAIL b2b_lw10 got=%h exp=c3", bus.reg_wdata);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_stack();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
